// File: rtl/slv_fifo_pkg.sv
// ---------------------------------------------------------------------------
// slv_fifo_pkg
// Shared definitions for the MCDF slave-channel FIFO.
//   clog2      : constant-evaluable ceiling log2, sizes the pointers
//   FIFO_DEPTH : entry count the pointer type is sized for
//   AW         : index width, clog2(FIFO_DEPTH)
//   ptr_t      : read/write pointer with one extra wrap bit, logic [AW:0]
// ---------------------------------------------------------------------------
package slv_fifo_pkg;

   // Smallest r such that 2**r >= value
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

   localparam int FIFO_DEPTH = 32;
   localparam int AW         = clog2(FIFO_DEPTH);

   typedef logic [AW:0] ptr_t;

endpackage

// File: rtl/slv_sc_fifo_mag_cmp.sv
// ---------------------------------------------------------------------------
// mag_cmp
// Unsigned magnitude comparator, rippled bit by bit from the MSB down.
// The first bit position where a and b differ decides the result.
// Purely combinational.
// Ports:
//   a, b : W-bit unsigned operands
//   gt   : a > b
//   eq   : a == b
//   lt   : a < b
// ---------------------------------------------------------------------------
module mag_cmp #(
   parameter int W = 6
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         gt,
   output logic         eq,
   output logic         lt
);

   // Walk from the MSB; once a decision is made, lower bits are ignored
   always_comb begin
      gt = 1'b0;
      lt = 1'b0;
      for (int i = W - 1; i >= 0; i--) begin
         if (!gt && !lt) begin
            if (a[i] && !b[i]) begin
               gt = 1'b1;
            end else if (!a[i] && b[i]) begin
               lt = 1'b1;
            end
         end
      end
      eq = !gt && !lt;
   end

endmodule

// File: rtl/slv_sc_fifo.sv
// ---------------------------------------------------------------------------
// slv_sc_fifo
// Single-clock FIFO buffering one MCDF slave channel between the
// register-side writer and the arbiter-side reader. Pointers carry a wrap
// bit so full and empty fall out of pointer equality; all flags and the
// free-slot margin are registered alongside the pointers.
// Optional feature macro: SC_FIFO_WMARK_EN adds afull_o/aempty_o watermark
// flags computed through two mag_cmp instances.
// DEPTH must equal slv_fifo_pkg::FIFO_DEPTH (pointer type is sized there).
// Ports:
//   clk_i     clock, rising edge
//   rstn_i    synchronous active-low reset
//   wr_en_i   push request,  wdata_i push data (DW)
//   rd_en_i   pop request,   rdata_o registered pop data (DW)
//   rvalid_o  one-cycle pulse per accepted pop
//   full_o    no free entry,  empty_o no stored entry
//   margin_o  free entries 0..DEPTH (AW+1 bits)
//   ovf_o     one-cycle pulse, push rejected
//   udf_o     one-cycle pulse, pop rejected
//   afull_o   used >= AFULL   (SC_FIFO_WMARK_EN only)
//   aempty_o  used <= AEMPTY  (SC_FIFO_WMARK_EN only)
// ---------------------------------------------------------------------------
module slv_sc_fifo
   import slv_fifo_pkg::*;
#(
   parameter int DW     = 32,
   parameter int DEPTH  = FIFO_DEPTH
`ifdef SC_FIFO_WMARK_EN
 , parameter int AFULL  = 28
 , parameter int AEMPTY = 4
`endif
) (
   input  logic          clk_i,
   input  logic          rstn_i,
   input  logic          wr_en_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          rd_en_i,
   output logic [DW-1:0] rdata_o,
   output logic          rvalid_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [AW:0]   margin_o,
   output logic          ovf_o,
   output logic          udf_o
`ifdef SC_FIFO_WMARK_EN
 , output logic          afull_o
 , output logic          aempty_o
`endif
);

   logic [DW-1:0] r_mem [DEPTH];
   ptr_t          r_wptr;
   ptr_t          r_rptr;
   logic [DW-1:0] r_rdata;
   logic          r_rvalid;
   logic          r_full;
   logic          r_empty;
   ptr_t          r_margin;
   logic          r_ovf;
   logic          r_udf;

   logic          w_push;
   logic          w_pop;
   ptr_t          w_wptrNext;
   ptr_t          w_rptrNext;
   ptr_t          w_usedNext;
   logic          w_fullNext;
   logic          w_emptyNext;

   // Acceptance depends only on registered flags, so there is no
   // combinational path from the request inputs to any flag output
   always_comb begin
      w_push      = wr_en_i && !r_full;
      w_pop       = rd_en_i && !r_empty;
      w_wptrNext  = r_wptr + ptr_t'(w_push);
      w_rptrNext  = r_rptr + ptr_t'(w_pop);
      w_usedNext  = w_wptrNext - w_rptrNext;
      w_emptyNext = (w_wptrNext == w_rptrNext);
      w_fullNext  = (w_wptrNext[AW] != w_rptrNext[AW]) &&
                    (w_wptrNext[AW-1:0] == w_rptrNext[AW-1:0]);
   end

   // Storage is intentionally left uncleared by reset
   always_ff @(posedge clk_i) begin
      if (rstn_i && w_push) begin
         r_mem[r_wptr[AW-1:0]] <= wdata_i;
      end
   end

   // Pointers, read data and flags all advance on the same edge
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
         r_margin <= ptr_t'(DEPTH);
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
      end else begin
         r_wptr   <= w_wptrNext;
         r_rptr   <= w_rptrNext;
         r_rvalid <= w_pop;
         if (w_pop) begin
            r_rdata <= r_mem[r_rptr[AW-1:0]];
         end
         r_full   <= w_fullNext;
         r_empty  <= w_emptyNext;
         r_margin <= ptr_t'(DEPTH) - w_usedNext;
         r_ovf    <= wr_en_i && r_full;
         r_udf    <= rd_en_i && r_empty;
      end
   end

   assign rdata_o  = r_rdata;
   assign rvalid_o = r_rvalid;
   assign full_o   = r_full;
   assign empty_o  = r_empty;
   assign margin_o = r_margin;
   assign ovf_o    = r_ovf;
   assign udf_o    = r_udf;

`ifdef SC_FIFO_WMARK_EN
   logic w_afGt, w_afEq, w_afLt;
   logic w_aeGt, w_aeEq, w_aeLt;
   logic r_afull;
   logic r_aempty;

   // Watermarks look at the post-update occupancy so they line up with
   // the registered margin
   mag_cmp #(.W(AW + 1)) u_afullCmp (
      .a  (w_usedNext),
      .b  (ptr_t'(AFULL)),
      .gt (w_afGt),
      .eq (w_afEq),
      .lt (w_afLt)
   );

   mag_cmp #(.W(AW + 1)) u_aemptyCmp (
      .a  (w_usedNext),
      .b  (ptr_t'(AEMPTY)),
      .gt (w_aeGt),
      .eq (w_aeEq),
      .lt (w_aeLt)
   );

   // The comparator outputs are one-hot; the extra term only keeps every
   // output of both instances observable
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         r_afull  <= 1'b0;
         r_aempty <= 1'b1;
      end else begin
         r_afull  <= (w_afGt || w_afEq) && !w_afLt;
         r_aempty <= (w_aeLt || w_aeEq) && !w_aeGt;
      end
   end

   assign afull_o  = r_afull;
   assign aempty_o = r_aempty;
`endif

endmodule

// File: tb/tb_slv_sc_fifo.sv
// ---------------------------------------------------------------------------
// tb_slv_sc_fifo
// Directed self-checking bench for slv_sc_fifo (DEPTH=32, DW=32).
// Define SC_FIFO_WMARK_EN to also exercise the watermark flags.
// ---------------------------------------------------------------------------
module tb_slv_sc_fifo;
   import slv_fifo_pkg::*;

   logic          clk;
   logic          rstn;
   logic          wrEn;
   logic [31:0]   wdata;
   logic          rdEn;
   logic [31:0]   rdata;
   logic          rvalid;
   logic          full;
   logic          empty;
   logic [AW:0]   margin;
   logic          ovf;
   logic          udf;
`ifdef SC_FIFO_WMARK_EN
   logic          afull;
   logic          aempty;
`endif

   int nChecks;
   int nBad;

   slv_sc_fifo #(.DW(32), .DEPTH(32)) dut (
      .clk_i    (clk),
      .rstn_i   (rstn),
      .wr_en_i  (wrEn),
      .wdata_i  (wdata),
      .rd_en_i  (rdEn),
      .rdata_o  (rdata),
      .rvalid_o (rvalid),
      .full_o   (full),
      .empty_o  (empty),
      .margin_o (margin),
      .ovf_o    (ovf),
      .udf_o    (udf)
`ifdef SC_FIFO_WMARK_EN
    , .afull_o  (afull)
    , .aempty_o (aempty)
`endif
   );

   // Free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one cycle of requests, then land 1 ns after the capturing edge
   task automatic applyStimulus(input logic w, input logic [31:0] d, input logic r);
      wrEn  = w;
      wdata = d;
      rdEn  = r;
      @(posedge clk);
      #1;
   endtask

   // Single comparison point; counts and reports any difference
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nBad++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Directed sequence
   initial begin
      nChecks = 0;
      nBad    = 0;
      rstn    = 1'b0;
      wrEn    = 1'b0;
      wdata   = '0;
      rdEn    = 1'b0;

      // Reset, with a push/pop request that must be ignored
      applyStimulus(1'b1, 32'hAAAA_AAAA, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b0);
      rstn = 1'b1;
      checkOutput("rst_rdata", rdata, 32'h0);
      checkOutput("rst_ovf", 32'(ovf), 32'd0);
      checkOutput("rst_udf", 32'(udf), 32'd0);
`ifdef SC_FIFO_WMARK_EN
      checkOutput("rst_afull", 32'(afull), 32'd0);
      checkOutput("rst_aempty", 32'(aempty), 32'd1);
`endif

      // Idle for 10 cycles
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, 32'h0, 1'b0);
         checkOutput("idle_empty", 32'(empty), 32'd1);
         checkOutput("idle_full", 32'(full), 32'd0);
         checkOutput("idle_margin", 32'(margin), 32'd32);
         checkOutput("idle_rvalid", 32'(rvalid), 32'd0);
      end

      // Fill with 0x00..0x1F
      for (int i = 0; i < 32; i++) begin
         applyStimulus(1'b1, 32'(i), 1'b0);
         checkOutput("fill_margin", 32'(margin), 32'(31 - i));
         checkOutput("fill_full", 32'(full), (i == 31) ? 32'd1 : 32'd0);
         checkOutput("fill_empty", 32'(empty), 32'd0);
      end

      // Push into a full FIFO
      applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0);
      checkOutput("ovf_pulse", 32'(ovf), 32'd1);
      checkOutput("ovf_full", 32'(full), 32'd1);
      checkOutput("ovf_margin", 32'(margin), 32'd0);
      applyStimulus(1'b0, 32'h0, 1'b0);
      checkOutput("ovf_clear", 32'(ovf), 32'd0);

      // Drain: data in order, 1-cycle latency
      for (int i = 0; i < 32; i++) begin
         applyStimulus(1'b0, 32'h0, 1'b1);
         checkOutput("drain_rvalid", 32'(rvalid), 32'd1);
         checkOutput("drain_rdata", rdata, 32'(i));
         checkOutput("drain_margin", 32'(margin), 32'(i + 1));
         checkOutput("drain_empty", 32'(empty), (i == 31) ? 32'd1 : 32'd0);
      end

      // Pop from an empty FIFO
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("udf_pulse", 32'(udf), 32'd1);
      checkOutput("udf_rvalid", 32'(rvalid), 32'd0);
      checkOutput("udf_rdata_hold", rdata, 32'h1F);
      applyStimulus(1'b0, 32'h0, 1'b0);
      checkOutput("udf_clear", 32'(udf), 32'd0);
      checkOutput("hold_rdata", rdata, 32'h1F);

      // Wrap: 3 rounds of 20 pushes then 20 pops, pointers start at 32
      for (int rnd = 0; rnd < 3; rnd++) begin
         for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b1, 32'h1000 * (rnd + 1) + 32'(k), 1'b0);
            checkOutput("wrap_fill_full", 32'(full), 32'd0);
         end
         checkOutput("wrap_margin", 32'(margin), 32'd12);
         for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b1);
            checkOutput("wrap_rdata", rdata, 32'h1000 * (rnd + 1) + 32'(k));
         end
         checkOutput("wrap_empty", 32'(empty), 32'd1);
         checkOutput("wrap_full", 32'(full), 32'd0);
      end

      // Simultaneous push+pop at used=16
      for (int k = 0; k < 16; k++) begin
         applyStimulus(1'b1, 32'h100 + 32'(k), 1'b0);
      end
      checkOutput("sim16_pre_margin", 32'(margin), 32'd16);
      applyStimulus(1'b1, 32'h200, 1'b1);
      checkOutput("sim16_margin", 32'(margin), 32'd16);
      checkOutput("sim16_rvalid", 32'(rvalid), 32'd1);
      checkOutput("sim16_rdata", rdata, 32'h100);

      // Top up to full, then push+pop at full: pop taken, push dropped
      for (int k = 0; k < 16; k++) begin
         applyStimulus(1'b1, 32'h300 + 32'(k), 1'b0);
      end
      checkOutput("top_full", 32'(full), 32'd1);
      applyStimulus(1'b1, 32'h400, 1'b1);
      checkOutput("fullrw_ovf", 32'(ovf), 32'd1);
      checkOutput("fullrw_margin", 32'(margin), 32'd1);
      checkOutput("fullrw_rdata", rdata, 32'h101);
      checkOutput("fullrw_full", 32'(full), 32'd0);

      // Remaining order: 0x102..0x10F, 0x200, 0x300..0x30F (0x400 dropped)
      for (int k = 0; k < 31; k++) begin
         applyStimulus(1'b0, 32'h0, 1'b1);
         if (k < 14) begin
            checkOutput("fullrw_drain", rdata, 32'h102 + 32'(k));
         end else if (k == 14) begin
            checkOutput("fullrw_drain", rdata, 32'h200);
         end else begin
            checkOutput("fullrw_drain", rdata, 32'h300 + 32'(k - 15));
         end
      end
      checkOutput("fullrw_empty", 32'(empty), 32'd1);

      // Reset mid-stream at used=10
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1'b1, 32'h500 + 32'(k), 1'b0);
      end
      checkOutput("pre_rst_margin", 32'(margin), 32'd22);
      rstn = 1'b0;
      applyStimulus(1'b1, 32'h0, 1'b1);
      rstn = 1'b1;
      checkOutput("mid_rst_empty", 32'(empty), 32'd1);
      checkOutput("mid_rst_margin", 32'(margin), 32'd32);
      checkOutput("mid_rst_rvalid", 32'(rvalid), 32'd0);
      checkOutput("mid_rst_rdata", rdata, 32'h0);

`ifdef SC_FIFO_WMARK_EN
      // Watermarks while filling from empty: aempty falls at 5, afull rises at 28
      for (int u = 1; u <= 32; u++) begin
         applyStimulus(1'b1, 32'(u), 1'b0);
         checkOutput("wm_afull", 32'(afull), (u >= 28) ? 32'd1 : 32'd0);
         checkOutput("wm_aempty", 32'(aempty), (u <= 4) ? 32'd1 : 32'd0);
      end
      // And while draining back down
      for (int u = 31; u >= 0; u--) begin
         applyStimulus(1'b0, 32'h0, 1'b1);
         checkOutput("wm_dn_afull", 32'(afull), (u >= 28) ? 32'd1 : 32'd0);
         checkOutput("wm_dn_aempty", 32'(aempty), (u <= 4) ? 32'd1 : 32'd0);
      end
`endif

      applyStimulus(1'b0, 32'h0, 1'b0);
      $display("test done: total=%0d bad=%0d", nChecks, nBad);
      $finish;
   end

   // Hard stop in case the sequence ever stalls
   initial begin
      #200000;
      $display("[TB] FAIL timeout observed=running expected=finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
